vga_marker_scheduler: RTL and testbench
=======================================

# vga_marker_scheduler

Sequences line-marker indices into the one-hot line storage stage of the VGA system. Accepts index requests from up to NUM_REQ producers through a round-robin arbiter and buffers them in a small FIFO. Presents exactly one index per video frame on a stable `data_out` bus, so the storage stage always samples a settled value on its vsync edge. Sits between the marker producers (detectors, overlay logic) and the storage stage.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- IDX_W, 16, index width; matches the storage stage data input
- LINES, 480, number of valid lines; indices 0..LINES-1 are in range
- FIFO_DEPTH, 8, queued indices (power of two)
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- vsync  in  1  frame sync; asynchronous to clk, synchronised internally
- req_valid  in  NUM_REQ  per-requester request valid
- req_idx  in  NUM_REQ*IDX_W  packed indices; requester r uses bits [r*IDX_W +: IDX_W]
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high
- data_out  out  IDX_W  index presented to the storage stage for the current frame
- data_valid  out  1  data_out holds a real marker (0 means idle value LINES)
- frame_strobe  out  1  one-cycle pulse when data_out updates
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- drop_count  out  8  saturating count of rejected out-of-range indices

## Operation
- Reset values: req_ready=0, data_out=LINES, data_valid=0, frame_strobe=0, fifo_count=0, drop_count=0. FSM resets to S_WAIT. Both vsync sync flops and the edge-history flop reset to 1, so a vsync that is high at reset release gives no spurious edge.
- Arbitration: round-robin with a rotating priority pointer.
  - When the FIFO is not full, grant the first valid requester at or after the pointer. At most one grant per cycle.
  - After a grant, the pointer moves to grantee+1, modulo NUM_REQ.
  - req_ready is combinational from req_valid, the pointer and registered full. When full, all ready lines are 0.
- FSM, three states:
  - S_WAIT: hold outputs; on a synchronised vsync rising edge go to S_POP.
  - S_POP (one cycle):
    - FIFO non-empty: data_out <= head, data_valid <= 1, pop.
    - FIFO empty: data_out <= LINES, data_valid <= 0.
    - In both cases frame_strobe <= 1, then go to S_HOLD.
  - S_HOLD: frame_strobe <= 0; data_out stays stable; go to S_WAIT when synchronised vsync is low.
  - A vsync edge while in S_POP/S_HOLD is not possible (S_HOLD waits for vsync low first). Edges are never queued.
- Push and pop in the same cycle are allowed; fifo_count is unchanged. Push eligibility uses full as registered before the pop.
- Reset asserted mid-frame: FIFO flushed, pointer reset to 0, outputs return to reset values on the next clk edge.

## Timing
- vsync first sampled high at clk edge k gives an edge detected after edge k+1. data_out, data_valid and frame_strobe update at edge k+2, then hold until the next frame.
- Request to FIFO: accepted index is visible in fifo_count on the clk edge after the handshake.
- Throughput: at most one accepted request per clk, and one pop per frame.
- fifo_count arithmetic is unsigned and never wraps. drop_count saturates at 255.

## Configuration
- MARKER_RANGE_CHECK_EN defined:
  - Accepted indices >= LINES are consumed (handshake completes) but not written to the FIFO.
  - drop_count increments, saturating.
- Not defined:
  - All accepted indices are queued unchanged. Out-of-range values reach data_out with data_valid=1.
  - drop_count is tied to 0.

## Structure
- Shared package vga_pkg holds: LINES and IDX_W defaults, the FSM state enum (S_WAIT, S_POP, S_HOLD), and the idle-index constant (LINES).
- One sub-module: rr_arbiter (NUM_REQ-wide round-robin grant with a pointer update input). FIFO and synchroniser stay inline.

## Test plan
- Reset with vsync held high, then release -> no frame_strobe, data_out=480, data_valid=0.
- Requester 2 sends 100, then a vsync pulse -> 3 clk after vsync sampled high: data_out=100, data_valid=1, one-cycle frame_strobe.
- All 4 requesters hold valid with indices 10,11,12,13 -> grants in order 0,1,2,3, then four frames present 10,11,12,13.
- Fill FIFO to 8 entries and keep requesting -> req_ready all 0. On a vsync pop, exactly one further grant follows on the next cycle.
- With MARKER_RANGE_CHECK_EN, send 479 then 480 -> 479 is queued, 480 dropped, drop_count=1. Without the macro, 480 is presented with data_valid=1.
- Assert rst_n low during S_HOLD with 3 entries queued -> fifo_count=0, data_out=480, and the next vsync presents idle.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA marker path.
// Used by vga_marker_scheduler (optional feature macro: MARKER_RANGE_CHECK_EN).
package vga_pkg;

  localparam int LINES_DEF = 480;
  localparam int IDX_W_DEF = 16;

  // Value presented on data_out when no marker is queued for the frame.
  localparam int IDLE_IDX = LINES_DEF;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_POP  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters with a rotating priority pointer.
// The pointer advances to grantee+1 whenever the caller signals a completed transfer.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               update,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx
);

  logic [PTR_W-1:0] ptr_r;
  logic             found_s;
  int               cand_s;

  // Search from the pointer for the first valid requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    cand_s    = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_s = (int'(ptr_r) + off) % NUM_REQ;
      if (enable && !found_s && valid[cand_s]) begin
        found_s           = 1'b1;
        grant[cand_s]     = 1'b1;
        grant_idx         = PTR_W'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (update) begin
      ptr_r <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/vga_marker_scheduler.sv
// Arbitrates marker indices into a FIFO and presents one index per vsync frame.
// Optional feature macro: MARKER_RANGE_CHECK_EN (drop indices >= LINES, count drops).
module vga_marker_scheduler
  import vga_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int IDX_W      = IDX_W_DEF,
  parameter int LINES      = LINES_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vsync,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [IDX_W-1:0]         data_out,
  output logic                     data_valid,
  output logic                     frame_strobe,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [7:0]               drop_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] IDLE_VAL = IDX_W'(LINES);

  logic             vs_meta_r, vs_sync_r, vs_prev_r, rise_s;
  logic [IDX_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s, empty_s, accept_s, push_s, pop_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [PTR_W-1:0]   grant_idx_s;
  logic [IDX_W-1:0]   sel_idx_s;
  state_t             state_r, state_next;
  logic [IDX_W-1:0]   data_r, data_next;
  logic               valid_r, valid_next, strobe_r, strobe_next;

  // vsync synchroniser and edge history; all ones at reset so a high vsync is not an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_meta_r <= 1'b1;
      vs_sync_r <= 1'b1;
      vs_prev_r <= 1'b1;
    end else begin
      vs_meta_r <= vsync;
      vs_sync_r <= vs_meta_r;
      vs_prev_r <= vs_sync_r;
    end
  end

  assign rise_s  = vs_sync_r & ~vs_prev_r;
  assign full_s  = (count_r == CW'(FIFO_DEPTH));
  assign empty_s = (count_r == CW'(0));

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (!full_s && rst_n),
    .update    (accept_s),
    .valid     (req_valid),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  assign req_ready = grant_s;
  assign accept_s  = |grant_s;
  assign sel_idx_s = req_idx[grant_idx_s*IDX_W +: IDX_W];

`ifdef MARKER_RANGE_CHECK_EN
  logic       in_range_s;
  logic [7:0] drop_r;

  assign in_range_s = (sel_idx_s < IDLE_VAL);
  assign push_s     = accept_s & in_range_s;

  // Saturating count of accepted but out-of-range indices.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_r <= 8'd0;
    end else if (accept_s && !in_range_s && (drop_r != 8'hFF)) begin
      drop_r <= drop_r + 8'd1;
    end else begin
      drop_r <= drop_r;
    end
  end

  assign drop_count = drop_r;
`else
  assign push_s     = accept_s;
  assign drop_count = 8'd0;
`endif

  // FIFO storage; contents need no reset because occupancy guards reads.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= sel_idx_s;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
      rd_ptr_r <= pop_s  ? rd_ptr_r + AW'(1) : rd_ptr_r;
      count_r  <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // Frame FSM; outputs are registered on entry to S_POP so they settle one frame early.
  always_comb begin
    state_next  = state_r;
    pop_s       = 1'b0;
    data_next   = data_r;
    valid_next  = valid_r;
    strobe_next = 1'b0;
    case (state_r)
      S_WAIT: begin
        if (rise_s) begin
          state_next  = S_POP;
          strobe_next = 1'b1;
          if (!empty_s) begin
            data_next  = mem_r[rd_ptr_r];
            valid_next = 1'b1;
            pop_s      = 1'b1;
          end else begin
            data_next  = IDLE_VAL;
            valid_next = 1'b0;
          end
        end else begin
          state_next = S_WAIT;
        end
      end
      S_POP: begin
        state_next = S_HOLD;
      end
      S_HOLD: begin
        if (!vs_sync_r) begin
          state_next = S_WAIT;
        end else begin
          state_next = S_HOLD;
        end
      end
      default: begin
        state_next = S_WAIT;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= S_WAIT;
      data_r   <= IDLE_VAL;
      valid_r  <= 1'b0;
      strobe_r <= 1'b0;
    end else begin
      state_r  <= state_next;
      data_r   <= data_next;
      valid_r  <= valid_next;
      strobe_r <= strobe_next;
    end
  end

  assign data_out     = data_r;
  assign data_valid   = valid_r;
  assign frame_strobe = strobe_r;
  assign fifo_count   = count_r;

endmodule

// File: tb/tb_vga_marker_scheduler.sv
// Scoreboard bench for vga_marker_scheduler: a frame model queues expected
// presentations, a negedge monitor checks them whenever frame_strobe fires.
module tb_vga_marker_scheduler;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           vsync = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_idx = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   data_out;
  logic           data_valid;
  logic           frame_strobe;
  logic [3:0]     fifo_count;
  logic [7:0]     drop_count;

  vga_marker_scheduler #(.NUM_REQ(N), .IDX_W(W), .LINES(480), .FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vsync        (vsync),
    .req_valid    (req_valid),
    .req_idx      (req_idx),
    .req_ready    (req_ready),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .frame_strobe (frame_strobe),
    .fifo_count   (fifo_count),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        v;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  int   model_q[$];
  logic prev_strobe = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every frame_strobe must match the oldest expected frame.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && frame_strobe) begin
      chk("strobe_single_cycle", {31'd0, prev_strobe}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: got data_out=%0d, expected no strobe", data_out);
      end else begin
        e = exp_q.pop_front();
        chk("frame_data", {16'd0, data_out}, {16'd0, e.d});
        chk("frame_valid", {31'd0, data_valid}, {31'd0, e.v});
      end
    end
    prev_strobe = rst_n && frame_strobe;
  end

  // One vsync frame; counts cycles in which any ready line was high.
  task automatic frame(output int grants);
    int   lat;
    bit   seen;
    exp_t e;
    grants = 0;
    if (model_q.size() > 0) begin
      e.d = 16'(model_q.pop_front());
      e.v = 1'b1;
    end else begin
      e.d = 16'd480;
      e.v = 1'b0;
    end
    exp_q.push_back(e);
    vsync = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (req_ready != '0) grants++;
      if (frame_strobe) seen = 1'b1;
    end
    chk("frame_latency", lat, 32'd3);
    repeat (2) begin
      @(posedge clk); #1;
      if (req_ready != '0) grants++;
    end
    chk("hold_data", {16'd0, data_out}, {16'd0, e.d});
    chk("hold_strobe_low", {31'd0, frame_strobe}, 32'd0);
    vsync = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (req_ready != '0) grants++;
    end
  endtask

  task automatic send(input int r, input int idx, input logic [N-1:0] exp_ready);
    req_valid[r] = 1'b1;
    req_idx[r*W +: W] = 16'(idx);
    #1;
    chk("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_fifo_count", {28'd0, fifo_count}, 32'd0);
    chk("rst_data_out", {16'd0, data_out}, 32'd480);
    chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_strobe", {31'd0, frame_strobe}, 32'd0);
    chk("rst_drop", {24'd0, drop_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    model_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    #1;
    // Reset with vsync high, release: no strobe, idle outputs.
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    chk("idle_data", {16'd0, data_out}, 32'd480);
    chk("idle_valid", {31'd0, data_valid}, 32'd0);
    chk("idle_ready", {28'd0, req_ready}, 32'd0);
    vsync = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Single request from requester 2.
    send(2, 100, 4'b0100);
    model_q.push_back(100);
    chk("count_after_100", {28'd0, fifo_count}, 32'd1);
    frame(g);
    chk("count_after_pop", {28'd0, fifo_count}, 32'd0);

    // Four concurrent requesters from a fresh pointer.
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) req_idx[i*W +: W] = 16'(10 + i);
    for (int i = 0; i < N; i++) begin
      #1;
      chk("rr_grant", {28'd0, req_ready}, 32'(1 << i));
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
      model_q.push_back(10 + i);
    end
    chk("count_four", {28'd0, fifo_count}, 32'd4);
    for (int i = 0; i < N; i++) frame(g);

    // Fill to full and keep requesting.
    req_valid[1] = 1'b1;
    for (int n = 0; n < 8; n++) begin
      req_idx[1*W +: W] = 16'(200 + n);
      #1;
      chk("fill_ready", {28'd0, req_ready}, 32'b0010);
      @(posedge clk); #1;
      model_q.push_back(200 + n);
    end
    req_idx[1*W +: W] = 16'd208;
    #1;
    chk("full_ready", {28'd0, req_ready}, 32'd0);
    chk("full_count", {28'd0, fifo_count}, 32'd8);
    @(posedge clk); #1;
    chk("full_ready_hold", {28'd0, req_ready}, 32'd0);
    frame(g);
    chk("one_grant_after_pop", g, 32'd1);
    req_valid[1] = 1'b0;
    model_q.push_back(208);
    chk("refilled_count", {28'd0, fifo_count}, 32'd8);

    // Range boundary 479 / 480.
    do_reset();
    send(3, 479, 4'b1000);
    model_q.push_back(479);
    send(3, 480, 4'b1000);
`ifdef MARKER_RANGE_CHECK_EN
    chk("range_count", {28'd0, fifo_count}, 32'd1);
    chk("range_drop", {24'd0, drop_count}, 32'd1);
`else
    model_q.push_back(480);
    chk("range_count", {28'd0, fifo_count}, 32'd2);
    chk("range_drop", {24'd0, drop_count}, 32'd0);
`endif
    frame(g);
    frame(g);

    // Reset during S_HOLD with three entries still queued.
    for (int i = 0; i < 4; i++) begin
      send(0, 50 + i, 4'b0001);
      model_q.push_back(50 + i);
    end
    begin
      exp_t e;
      e.d = 16'(model_q.pop_front());
      e.v = 1'b1;
      exp_q.push_back(e);
    end
    vsync = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_queued", {28'd0, fifo_count}, 32'd3);
    chk("hold_value", {16'd0, data_out}, 32'd50);
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    vsync = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    frame(g);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
